lcd_cmd_sched: RTL
==================

# lcd_cmd_sched

Command scheduler in front of the LCD image controller. Buffers host display commands in a small FIFO and issues them one at a time on the controller's `cmd`/`cmd_valid` port, respecting its `busy` handshake. Holds off issue until the controller's initial image load finishes. Stops after a WRITE command completes, i.e. when the controller reports `done`.

## Interface

- DEPTH, 4, command FIFO depth; power of two, ≥ 2
- CW, 3, command width; matches the controller's `cmd` port

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- host_cmd  in  CW  command opcode from host: 0 WRITE, 1 SHIFT_UP, 2 SHIFT_DOWN, 3 SHIFT_LEFT, 4 SHIFT_RIGHT, 5 AVERAGE, 6 MIRROR_X, 7 MIRROR_Y
- host_valid  in  1  host push request
- host_ready  out  1  FIFO can accept; push happens on a cycle with `host_valid && host_ready`
- lcd_busy  in  1  controller `busy`
- lcd_done  in  1  controller `done`
- cmd  out  CW  command to controller; registered
- cmd_valid  out  1  one-cycle issue strobe; registered
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- err_drop  out  1  one-cycle pulse when `host_valid=1` and `host_ready=0`
- sched_done  out  1  level; set when the WRITE completes, cleared only by reset

## Operation

- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Push while full is dropped and raises `err_drop`. FIFO contents are untouched.
- `host_ready` = (fifo_count < DEPTH) && state != FIN. Combinational from registered state.
- FSM states: INIT, IDLE, GUARD, WAIT_BUSY, WAIT_DONE, FIN.
  - INIT: entered on reset. Moves to IDLE on the first edge where `lcd_busy`=0. Host pushes are accepted during INIT.
  - IDLE: if FIFO is non-empty and `lcd_busy`=0, then on that edge:
    - `cmd` <= head and `cmd_valid` <= 1;
    - pop the head;
    - go to GUARD.
    Otherwise stay in IDLE.
  - GUARD: `cmd_valid` <= 0. Go to WAIT_DONE if the issued `cmd` was WRITE (0), else WAIT_BUSY. GUARD covers the one-cycle delay before the controller raises `busy`; `lcd_busy` is ignored in GUARD.
  - WAIT_BUSY: go to IDLE on the first edge with `lcd_busy`=0.
  - WAIT_DONE: on the first edge with `lcd_done`=1: `sched_done` <= 1 and go to FIN.
  - FIN: terminal. No issue and `host_ready`=0. Remaining FIFO entries are retained but never issued. Pushes raise `err_drop`.
- `cmd` holds its last issued value between issues.
- Reset asserted mid-operation:
  - all state clears immediately;
  - FIFO is emptied (count 0, pointers 0);
  - any in-flight `cmd_valid` drops asynchronously.

## Timing

- Reset values:
  - `cmd`=0, `cmd_valid`=0, `fifo_count`=0, `err_drop`=0, `sched_done`=0;
  - `host_ready`=1;
  - state INIT.
- Push accepted at edge N: `fifo_count` increments after N. Earliest `cmd_valid` is high after edge N+1, if the FSM is in IDLE with `lcd_busy`=0.
- `cmd_valid` is high for exactly one cycle per command.
- Minimum spacing between issues is 3 cycles: issue, GUARD, WAIT_BUSY seeing `busy`=0.
- The pop happens on the issue edge, so `fifo_count` decrements in the same cycle `cmd_valid` rises.
- `err_drop` is registered and appears the cycle after the rejected push.
- `sched_done` rises one cycle after `lcd_done` is sampled high in WAIT_DONE.

## Test plan

- Reset release with `lcd_busy`=1 for 70 cycles, host pushes 3 (SHIFT_LEFT) at cycle 5 → no `cmd_valid` until `lcd_busy` falls. Then `cmd`=3 and `cmd_valid` pulse for one cycle, one cycle after the fall is sampled.
- Push 1,2,5,6 back-to-back with `lcd_busy` held 0 except 2 cycles after each issue → issues in order 1,2,5,6, each `cmd_valid` exactly 1 cycle wide; `fifo_count` goes 1,2,… and returns to 0.
- With DEPTH=4, `lcd_busy`=1, push 5 commands → `fifo_count`=4, `host_ready`=0, 5th push dropped with a single `err_drop` pulse. The first 4 are later issued in order.
- Full FIFO with push and pop in the same cycle (pop when `busy` falls, `host_valid` high while `host_ready`=1 on the following cycle) → count stays consistent. Check pointer wrap over 10 commands with no loss or reorder.
- Push 4 then 0 (WRITE) then 7; controller asserts `lcd_done` 20 cycles after the WRITE issue → `sched_done`=1 one cycle later, FSM in FIN, `host_ready`=0, command 7 never issued.
- Assert `reset`=0 while in WAIT_BUSY with 2 entries queued → all outputs return to reset values immediately, `fifo_count`=0, FSM resumes in INIT on release.

Source files
------------

// File: rtl/lcd_cmd_sched.sv
// Command scheduler for the LCD image controller: a small command FIFO plus an
// issue FSM that paces commands on the controller's busy/done handshake.
module lcd_cmd_sched #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CW-1:0]            host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    input  logic                     lcd_busy,
    input  logic                     lcd_done,
    output logic [CW-1:0]            cmd,
    output logic                     cmd_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_drop,
    output logic                     sched_done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_GUARD     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FIN       = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [CW-1:0]     mem_q [DEPTH];
    logic [CW-1:0]     mem_d [DEPTH];
    logic [CW-1:0]     cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              err_drop_q, err_drop_d;
    logic              sched_done_q, sched_done_d;
    logic              push_s;
    logic              pop_s;

    assign host_ready = (count_q < CNTW'(DEPTH)) && (state_q != ST_FIN);
    assign push_s     = host_valid && host_ready;

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign fifo_count = count_q;
    assign err_drop   = err_drop_q;
    assign sched_done = sched_done_q;

    // Issue FSM: next state, issue strobe and the pop request.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        sched_done_d = sched_done_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (!lcd_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                // Pop decision uses pre-edge occupancy, so a push never issues on the same edge.
                if ((count_q != {CNTW{1'b0}}) && !lcd_busy) begin
                    cmd_d       = mem_q[rd_ptr_q];
                    cmd_valid_d = 1'b1;
                    pop_s       = 1'b1;
                    state_d     = ST_GUARD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (cmd_q == {CW{1'b0}}) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!lcd_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (lcd_done) begin
                    sched_done_d = 1'b1;
                    state_d      = ST_FIN;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_FIN: begin
                state_d = ST_FIN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // FIFO storage, pointers and occupancy; rejected pushes only flag err_drop.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_drop_d = host_valid && !host_ready;
        if (push_s) begin
            mem_d[wr_ptr_q] = host_cmd;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset clears everything, including any in-flight strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            rd_ptr_q     <= {AW{1'b0}};
            wr_ptr_q     <= {AW{1'b0}};
            count_q      <= {CNTW{1'b0}};
            cmd_q        <= {CW{1'b0}};
            cmd_valid_q  <= 1'b0;
            err_drop_q   <= 1'b0;
            sched_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {CW{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            err_drop_q   <= err_drop_d;
            sched_done_q <= sched_done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
